// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the 4:1 mux scan controller: FSM states,
// channel count, select width and the default settle time.
package mux_scan_pkg;

  localparam int NCH            = 4;
  localparam int SEL_W          = 2;
  localparam int CNT_W          = 4;
  localparam int DEFAULT_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux select/data and result signals between the scan
// controller (slave) and whoever requests scans and owns the mux (master).
interface mux_scan_ctrl_if;

  logic       start;
  logic       abort;
  logic       mux_out;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       done;
  logic [3:0] sample;
  logic       max_valid;
  logic [1:0] max_idx;

  modport slave (
    input  start, abort, mux_out,
    output s1, s0, busy, done, sample, max_valid, max_idx
  );

  modport master (
    output start, abort, mux_out,
    input  s1, s0, busy, done, sample, max_valid, max_idx
  );

endinterface

// File: rtl/mux_scan_ctrl_prio_enc4.sv
// 4-bit priority encoder: reports whether any bit is set and the index
// of the highest set bit (0 when nothing is set).
module prio_enc4 (
  input  logic [3:0] vec,
  output logic       valid,
  output logic [1:0] idx
);

  // Highest set bit wins; the index defaults to 0 for an all-zero vector.
  always_comb begin
    valid = |vec;
    idx   = 2'd0;
    if (vec[3])      idx = 2'd3;
    else if (vec[2]) idx = 2'd2;
    else if (vec[1]) idx = 2'd1;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the select lines of a downstream 4:1 mux through all channels,
// waits SETTLE cycles on each, captures the mux output into a shadow
// register and publishes the result with a priority-encoded summary.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input logic              clk,
  input logic              rst_n,
  mux_scan_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NCH - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             publish;

  logic [NCH-1:0]   sample_q;
  logic             max_valid_q;
  logic [1:0]       max_idx_q;

  logic             enc_valid;
  logic [1:0]       enc_idx;

  // Summary of the shadow contents as they will look after this edge, so
  // the registered result lines up with the published sample.
  prio_enc4 u_prio_enc4 (
    .vec   (shadow_d),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Next-state logic; abort cancels SETTLE/SAMPLE but never a DONE pulse.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    publish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = ST_SETTLE;
          ch_d     = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          shadow_d[ch_q] = bus.mux_out;
          if (ch_q == LAST_CH) begin
            state_d = ST_DONE;
            ch_d    = '0;
            cnt_d   = '0;
            publish = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            ch_d    = ch_q + 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
        cnt_d   = '0;
      end
    endcase

    sel_d = ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) ? ch_d : '0;
  end

  // Scan state, channel, settle counter, shadow and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
    end
  end

  // Published results change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      max_valid_q <= 1'b0;
      max_idx_q   <= '0;
    end else if (publish) begin
      sample_q    <= shadow_d;
      max_valid_q <= enc_valid;
      max_idx_q   <= enc_idx;
    end
  end

  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.sample    = sample_q;
  assign bus.max_valid = max_valid_q;
  assign bus.max_idx   = max_idx_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) share the
// same stimulus and are compared every cycle against a timeline model of
// a scan, plus directed checks of the published results and latency.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] ivec;

  int n_checks = 0;
  int n_fails  = 0;

  mux_scan_ctrl_if bus1 ();
  mux_scan_ctrl_if bus3 ();

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  assign bus1.start   = start;
  assign bus1.abort   = abort;
  assign bus1.mux_out = ivec[{bus1.s1, bus1.s0}];
  assign bus3.start   = start;
  assign bus3.abort   = abort;
  assign bus3.mux_out = ivec[{bus3.s1, bus3.s0}];

  mux_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  mux_scan_ctrl #(.SETTLE(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Reference model: a scan is a timeline of 4*(S+1) busy cycles followed
  // by one done cycle; pos is the cycle number within it (-1 when idle).
  int         settle_of [2] = '{1, 3};
  int         pos       [2];
  logic [3:0] mshadow   [2];
  logic [3:0] msample   [2];

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      pos[d]     = -1;
      mshadow[d] = 4'b0;
      msample[d] = 4'b0;
    end
  endtask

  task automatic modelStep();
    int per;
    int chn;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      per = settle_of[d] + 1;
      if (pos[d] == 4 * per) begin
        pos[d] = -1;
      end else if (pos[d] >= 0) begin
        if (abort) begin
          pos[d] = -1;
        end else begin
          chn = pos[d] / per;
          if ((pos[d] % per) == per - 1) mshadow[d][chn] = ivec[chn];
          pos[d] = pos[d] + 1;
          if (pos[d] == 4 * per) msample[d] = mshadow[d];
        end
      end else if (start && !abort) begin
        pos[d]     = 0;
        mshadow[d] = 4'b0;
      end
    end
  endtask

  function automatic int hiIdx(input logic [3:0] v);
    int r = 0;
    for (int b = 0; b < 4; b++) if (v[b]) r = b;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic checkInstance(input string tag, input int d, input logic busy_a,
                               input logic done_a, input logic [1:0] sel_a,
                               input logic [3:0] sample_a, input logic valid_a,
                               input logic [1:0] idx_a);
    int   per;
    logic eb;
    per = settle_of[d] + 1;
    eb  = (pos[d] >= 0) && (pos[d] < 4 * per);
    checkOutput({tag, " busy"},   8'(busy_a),   8'(eb));
    checkOutput({tag, " done"},   8'(done_a),   8'(pos[d] == 4 * per));
    checkOutput({tag, " sel"},    8'(sel_a),    eb ? 8'(pos[d] / per) : 8'd0);
    checkOutput({tag, " sample"}, 8'(sample_a), 8'(msample[d]));
    checkOutput({tag, " valid"},  8'(valid_a),  8'(msample[d] != 4'b0));
    checkOutput({tag, " idx"},    8'(idx_a),    8'(hiIdx(msample[d])));
  endtask

  task automatic checkAll();
    checkInstance("S1", 0, bus1.busy, bus1.done, {bus1.s1, bus1.s0},
                  bus1.sample, bus1.max_valid, bus1.max_idx);
    checkInstance("S3", 1, bus3.busy, bus3.done, {bus3.s1, bus3.s0},
                  bus3.sample, bus3.max_valid, bus3.max_idx);
  endtask

  // One clock: model follows the rising edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic [3:0] iv);
    start = st;
    abort = ab;
    ivec  = iv;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    checkOutput("rst s1 outs", {bus1.s1, bus1.s0, bus1.busy, bus1.done,
                bus1.max_valid, bus1.max_idx}, 8'd0);
    checkOutput("rst s3 outs", {bus3.s1, bus3.s0, bus3.busy, bus3.done,
                bus3.max_valid, bus3.max_idx}, 8'd0);
    checkOutput("rst samples", {bus1.sample, bus3.sample}, 8'd0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic runScan(input logic [3:0] iv, output int lat1, output int lat3,
                         output int cnt1, output int cnt3);
    lat1 = -1; lat3 = -1; cnt1 = 0; cnt3 = 0;
    applyStimulus(1'b1, 1'b0, iv);
    tick();
    applyStimulus(1'b0, 1'b0, iv);
    for (int j = 1; j <= 24; j++) begin
      tick();
      if (bus1.done) begin cnt1++; if (lat1 < 0) lat1 = j; end
      if (bus3.done) begin cnt3++; if (lat3 < 0) lat3 = j; end
    end
  endtask

  initial begin
    int l1, l3, c1, c3;
    start = 1'b0; abort = 1'b0; ivec = 4'b0;
    $display("[TB] starting mux_scan_ctrl bench");
    applyReset();

    // Mixed channels, both settle times.
    runScan(4'b0101, l1, l3, c1, c3);
    checkOutput("lat S1 0101", 8'(l1), 8'd8);
    checkOutput("lat S3 0101", 8'(l3), 8'd16);
    checkOutput("done cnt S1", 8'(c1), 8'd1);
    checkOutput("done cnt S3", 8'(c3), 8'd1);
    checkOutput("S1 sample 0101", 8'(bus1.sample), 8'h05);
    checkOutput("S1 valid 0101", 8'(bus1.max_valid), 8'd1);
    checkOutput("S1 idx 0101", 8'(bus1.max_idx), 8'd2);

    // All-zero input.
    runScan(4'b0000, l1, l3, c1, c3);
    checkOutput("done cnt zero", 8'(c1), 8'd1);
    checkOutput("S1 sample 0000", 8'(bus1.sample), 8'h00);
    checkOutput("S1 valid 0000", 8'(bus1.max_valid), 8'd0);
    checkOutput("S1 idx 0000", 8'(bus1.max_idx), 8'd0);

    // Top channel only, long settle.
    runScan(4'b1000, l1, l3, c1, c3);
    checkOutput("lat S3 1000", 8'(l3), 8'd16);
    checkOutput("S3 sample 1000", 8'(bus3.sample), 8'h08);
    checkOutput("S3 idx 1000", 8'(bus3.max_idx), 8'd3);

    // Full scan, then an aborted scan that must leave the result alone.
    runScan(4'b1111, l1, l3, c1, c3);
    checkOutput("S1 sample 1111", 8'(bus1.sample), 8'h0F);
    applyStimulus(1'b1, 1'b0, 4'b0010);
    tick();
    applyStimulus(1'b0, 1'b0, 4'b0010);
    c1 = 0;
    for (int j = 1; j <= 4; j++) begin tick(); if (bus1.done) c1++; end
    checkOutput("S1 ch before abort", 8'({bus1.s1, bus1.s0}), 8'd2);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    tick();
    applyStimulus(1'b0, 1'b0, 4'b0010);
    for (int j = 0; j < 20; j++) begin tick(); if (bus1.done || bus3.done) c1++; end
    checkOutput("abort no done", 8'(c1), 8'd0);
    checkOutput("abort busy", 8'({bus1.busy, bus3.busy}), 8'd0);
    checkOutput("abort keeps 1111", 8'(bus1.sample), 8'h0F);
    runScan(4'b0010, l1, l3, c1, c3);
    checkOutput("S1 sample 0010", 8'(bus1.sample), 8'h02);
    checkOutput("S1 idx 0010", 8'(bus1.max_idx), 8'd1);
    checkOutput("S3 idx 0010", 8'(bus3.max_idx), 8'd1);

    // Reset during SAMPLE of channel 1 on the SETTLE=1 instance.
    applyStimulus(1'b1, 1'b0, 4'b0110);
    tick();
    applyStimulus(1'b0, 1'b0, 4'b0110);
    for (int j = 1; j <= 3; j++) tick();
    checkOutput("pre-rst busy", 8'(bus1.busy), 8'd1);
    checkOutput("pre-rst sel", 8'({bus1.s1, bus1.s0}), 8'd1);
    applyReset();

    // Start held through a busy period is not queued.
    applyStimulus(1'b1, 1'b0, 4'b1001);
    c1 = 0;
    for (int j = 0; j < 5; j++) begin tick(); if (bus1.done) c1++; end
    applyStimulus(1'b0, 1'b0, 4'b1001);
    for (int j = 0; j < 22; j++) begin tick(); if (bus1.done) c1++; end
    checkOutput("held start one done", 8'(c1), 8'd1);
    checkOutput("held start sample", 8'(bus1.sample), 8'h09);

    // Start and abort together in IDLE: abort wins.
    applyStimulus(1'b1, 1'b1, 4'b1111);
    tick();
    tick();
    checkOutput("start+abort busy", 8'({bus1.busy, bus3.busy}), 8'd0);
    applyStimulus(1'b0, 1'b0, 4'b1111);
    tick();

    // Randomized traffic with occasional aborts and resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyReset();
      end else begin
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : ivec);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, is the number of wait cycles after each select change before the mux output is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 abort  input  1  synchronous scan cancel.
REQ-006 mux_out  input  1  data output of the downstream 4:1 mux (out).
REQ-007 s1  output  1  mux select MSB; drives the mux s1 pin.
REQ-008 s0  output  1  mux select LSB; drives the mux s0 pin.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse when a scan completes.
REQ-011 sample  output  4  published captured values; bit n is the mux output with select n.
REQ-012 max_valid  output  1  high when published sample is non-zero.
REQ-013 max_idx  output  2  highest set index in published sample; 0 when sample is zero.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE: {s1,s0}=00 and busy=0; start=1 with abort=0 SHALL move to SETTLE with channel ch=0 and settle counter=0.
REQ-016 SETTLE: {s1,s0}=ch and busy=1; the counter SHALL increment each cycle; on counter==SETTLE-1 the FSM SHALL move to SAMPLE.
REQ-017 SAMPLE: {s1,s0}=ch and busy=1; the edge leaving SAMPLE SHALL write mux_out into shadow bit ch.
REQ-018 SAMPLE exit: ch<3 SHALL go to SETTLE with ch+1 and counter cleared; ch==3 SHALL go to DONE.
REQ-019 DONE: lasts exactly one cycle with done=1, busy=0 and {s1,s0}=00, then returns to IDLE.
REQ-020 sample, max_valid and max_idx SHALL update only on the edge entering DONE, so they are valid together with done and hold until the next completed scan.
REQ-021 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+4*(SETTLE+1).
REQ-022 The select lines SHALL be driven directly from registers, with no combinational path from any input.
REQ-023 start outside IDLE SHALL be ignored; it is not queued.
REQ-024 abort=1 in SETTLE or SAMPLE SHALL move to IDLE on the next edge, with no done and published outputs unchanged.
REQ-025 If start and abort are both high in IDLE, abort SHALL win and the FSM stays in IDLE.
REQ-026 abort in DONE SHALL have no effect; the done pulse completes.
REQ-027 The shadow register SHALL be cleared at each scan start.

Reset
REQ-028 While rst_n=0 the block SHALL hold: state=IDLE, ch=0, counter=0, shadow=0, s1=s0=0, busy=0, done=0, sample=0, max_valid=0, max_idx=0.
REQ-029 Reset asserted mid-scan SHALL abort immediately with no done pulse.
REQ-030 After reset release, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-031 Package mux_scan_pkg SHALL hold the state enumeration, the channel-count constant NCH=4, the select width 2 and the default SETTLE.
REQ-032 max_valid and max_idx SHALL be derived by a single combinational sub-module prio_enc4 (4-bit input; outputs valid and a 2-bit index).
REQ-033 The max_valid and max_idx results SHALL be registered at publication.

Verification
REQ-034 The bench SHALL model the 4:1 mux behaviourally, driving mux_out from registered select and a 4-bit i vector.
REQ-035 SETTLE=1, i=0101, start pulse -> select sequence 00,00,01,01,10,10,11,11; done at edge+9; sample=0101, max_valid=1, max_idx=2.
REQ-036 i=0000, scan -> sample=0000, max_valid=0, max_idx=0; done pulse lasts exactly 1 cycle.
REQ-037 SETTLE=3, i=1000 -> each select held for 4 cycles; done at edge+17; max_idx=3.
REQ-038 i=1111, scan completes; then i=0010 with abort while ch=2 -> returns to IDLE, no done, sample stays 1111; next full scan gives 0010 and max_idx=1.
REQ-039 rst_n low during the SAMPLE state of ch=1 -> all outputs zero immediately; start held high during busy is ignored, and start together with abort in IDLE leaves busy=0.
